// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache miss-refill controller: refill FSM encoding,
// line geometry and the line-aligned address helper.
package cache_refill_ctrl_pkg;

  localparam int BEATS    = 8;
  localparam int BEAT_W   = 32;
  localparam int LINE_W   = BEATS * BEAT_W;
  localparam int OFFSET_W = 5;
  localparam int ADDR_W   = 32;
  localparam int LADDR_W  = ADDR_W - OFFSET_W;
  localparam int INDEX_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BEAT = 2'd2,
    FILL = 2'd3
  } refill_state_e;

  function automatic logic [ADDR_W-1:0] line_base(input logic [LADDR_W-1:0] line_addr);
    return {line_addr, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_assembler.sv
// Collects memory read beats into one cache line, lowest word first, and flags
// the beat that completes the line.
module line_assembler #(
  parameter int BEATS  = 8,
  parameter int BEAT_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat_en,
  input  logic [BEAT_W-1:0] beat_data,
  output logic [LINE_W-1:0] line_buf,
  output logic              last_beat
);
  import cache_refill_ctrl_pkg::*;

  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d;
  logic [BEATS-1:0]  slot_we;

  always_comb begin
    slot_we = '0;
    if (beat_en) begin
      slot_we[beat_cnt_q] = 1'b1;
    end
  end

  always_comb begin
    line_buf_d = line_buf_q;
    for (int i = 0; i < BEATS; i++) begin
      if (slot_we[i]) begin
        line_buf_d[i*BEAT_W +: BEAT_W] = beat_data;
      end
    end
  end

  // Counter wraps naturally after the final slot, ready for the next line.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clear) begin
      beat_cnt_d = '0;
    end else if (beat_en) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      line_buf_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      line_buf_q <= line_buf_d;
    end
  end

  assign line_buf  = line_buf_q;
  assign last_beat = beat_en & (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: stalls the pipeline on a cache miss, reads the missing
// line from memory beat by beat and hands it to the cache with a one-cycle fill.
module cache_refill_ctrl #(
  parameter int BEATS  = cache_refill_ctrl_pkg::BEATS,
  parameter int BEAT_W = cache_refill_ctrl_pkg::BEAT_W,
  parameter int LINE_W = cache_refill_ctrl_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              hit,
  input  logic [31:0]       pcOut,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [BEAT_W-1:0] mem_rdata,
  output logic              stall,
  output logic              fill_en,
  output logic [LINE_W-1:0] fill_line,
  output logic [2:0]        fill_index
);
  import cache_refill_ctrl_pkg::*;

  refill_state_e      state_q, state_d;
  logic [LADDR_W-1:0] line_addr_q, line_addr_d;
  logic               miss;
  logic               asm_clear;
  logic               beat_en;
  logic               last_beat;
  logic [LINE_W-1:0]  line_buf;
  logic               unused_pc_offset;

  assign unused_pc_offset = ^pcOut[OFFSET_W-1:0];

  assign miss      = req_valid & ~hit;
  assign asm_clear = (state_q == IDLE) & miss;
  assign beat_en   = (state_q == BEAT) & mem_rvalid;

  // Combinational so the pipeline freezes in the very cycle the miss shows up;
  // gated by reset so every output reads 0 while reset is held.
  assign stall = reset & ((state_q != IDLE) | miss);

  line_assembler #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W),
    .LINE_W (LINE_W)
  ) u_line_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .beat_en   (beat_en),
    .beat_data (mem_rdata),
    .line_buf  (line_buf),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    mem_req     = 1'b0;
    mem_addr    = '0;
    fill_en     = 1'b0;
    fill_line   = '0;
    fill_index  = '0;

    // Once a refill starts, only the latched line address matters.
    case (state_q)
      IDLE: begin
        if (miss) begin
          line_addr_d = pcOut[ADDR_W-1:OFFSET_W];
          state_d     = REQ;
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = line_base(line_addr_q);
        if (mem_gnt) begin
          state_d = BEAT;
        end
      end
      BEAT: begin
        mem_addr = line_base(line_addr_q);
        if (last_beat) begin
          state_d = FILL;
        end
      end
      FILL: begin
        mem_addr   = line_base(line_addr_q);
        fill_en    = 1'b1;
        fill_line  = line_buf;
        fill_index = line_addr_q[INDEX_W-1:0];
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a transaction-level refill model checked
// against the DUT every cycle, plus hand-computed timing and data expectations.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         hit = 1'b0;
  logic [31:0]  pcOut = '0;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         stall;
  logic         fill_en;
  logic [255:0] fill_line;
  logic [2:0]   fill_index;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  cache_refill_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .hit        (hit),
    .pcOut      (pcOut),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .fill_en    (fill_en),
    .fill_line  (fill_line),
    .fill_index (fill_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Refill model: a refill is "open" from the miss until the line has been
  // delivered; it is either waiting for a grant, collecting beats, or delivering.
  bit          m_busy = 0;
  bit          m_granted = 0;
  bit          m_deliver = 0;
  int          m_n = 0;
  bit [31:0]   m_beats [8];
  bit [26:0]   m_la = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy    <= 0;
      m_granted <= 0;
      m_deliver <= 0;
      m_n       <= 0;
    end else if (!m_busy) begin
      if (req_valid && !hit) begin
        m_busy    <= 1;
        m_granted <= 0;
        m_deliver <= 0;
        m_n       <= 0;
        m_la      <= pcOut[31:5];
      end
    end else if (m_deliver) begin
      m_busy    <= 0;
      m_deliver <= 0;
    end else if (!m_granted) begin
      if (mem_gnt) m_granted <= 1;
    end else if (mem_rvalid) begin
      m_beats[m_n] <= mem_rdata;
      m_n <= m_n + 1;
      if (m_n == 7) m_deliver <= 1;
    end
  end

  int           fill_cnt = 0;
  int           fill_cyc = 0;
  int           stall_cnt = 0;
  int           req_cnt = 0;
  logic [255:0] line_cap = '0;
  logic [2:0]   idx_cap = '0;
  logic [31:0]  addr_cap = '0;
  logic [255:0] e_line;

  always @(negedge clk) begin
    e_line = '0;
    if (m_deliver)
      for (int i = 0; i < 8; i++) e_line[32*i +: 32] = m_beats[i];
    chk("stall", stall, (reset === 1'b1) && (m_busy || (req_valid && !hit)));
    chk("mem_req", mem_req, m_busy && !m_granted);
    chk("mem_addr", mem_addr, m_busy ? {m_la, 5'b0} : 32'h0);
    chk("fill_en", fill_en, m_deliver);
    chk("fill_line", fill_line, e_line);
    chk("fill_index", fill_index, m_deliver ? m_la[2:0] : 3'd0);
    if (stall) stall_cnt++;
    if (mem_req) begin
      if (req_cnt == 0) addr_cap = mem_addr;
      req_cnt++;
    end
    if (fill_en) begin
      fill_cnt++;
      fill_cyc = cyc;
      line_cap = fill_line;
      idx_cap  = fill_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] p, input int gdly, input int gap_at, input int gap_len,
                        input logic [31:0] seed, input bit spur, input bit chg);
    fill_cnt = 0; stall_cnt = 0; req_cnt = 0;
    pcOut = p; req_valid = 1; hit = 0; mem_gnt = 0; mem_rvalid = 0;
    t0 = cyc;
    tick();
    mem_rvalid = spur; mem_rdata = 32'hDEADBEEF;
    repeat (gdly) tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0; mem_rvalid = 0;
    for (int b = 0; b < 8; b++) begin
      if (b == gap_at) begin
        mem_rvalid = 0;
        repeat (gap_len) tick();
      end
      mem_rvalid = 1;
      mem_rdata  = seed * (b + 1);
      if (chg && b == 4) pcOut = 32'hABCDABC0;
      tick();
    end
    mem_rvalid = 0;
    tick();
  endtask

  task automatic finish_hit();
    hit = 1;
    tick();
    req_valid = 0; hit = 0;
    tick();
  endtask

  int a_fill;

  initial begin
    // Reset held with random activity on every input.
    for (int i = 0; i < 5; i++) begin
      req_valid = $urandom_range(0, 1); hit = $urandom_range(0, 1);
      pcOut = $urandom; mem_gnt = $urandom_range(0, 1);
      mem_rvalid = $urandom_range(0, 1); mem_rdata = $urandom;
      tick();
    end
    req_valid = 1; hit = 0; #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fill", {fill_en, fill_index, fill_line}, '0);
    req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    tick();
    reset = 1;

    // Hits cost nothing.
    stall_cnt = 0; req_cnt = 0;
    req_valid = 1; hit = 1; pcOut = 32'h00001234;
    repeat (4) tick();
    req_valid = 0;
    tick();
    chk("hit_stall_cycles", stall_cnt, 0);
    chk("hit_mem_req_cycles", req_cnt, 0);

    // Basic miss.
    refill(32'h00A00062, 0, -1, 0, 32'h11111111, 0, 0);
    finish_hit();
    chk("basic_fill_count", fill_cnt, 1);
    chk("basic_fill_cycle", fill_cyc - t0, 10);
    chk("basic_addr", addr_cap, 32'h00A00060);
    chk("basic_word0", line_cap[31:0], 32'h11111111);
    chk("basic_word7", line_cap[255:224], 32'h88888888);
    chk("basic_index", idx_cap, 3'd3);
    chk("basic_stall_cycles", stall_cnt, 11);

    // Late grant plus a two-cycle gap in the beat stream.
    refill(32'h00A00062, 4, 3, 2, 32'h11111111, 0, 0);
    finish_hit();
    chk("slow_fill_cycle", fill_cyc - t0, 16);
    chk("slow_stall_cycles", stall_cnt, 17);
    chk("slow_req_cycles", req_cnt, 5);
    chk("slow_word3", line_cap[127:96], 32'h44444444);

    // Spurious beat during REQ and pcOut change mid-refill.
    refill(32'h12345678, 2, -1, 0, 32'h01020304, 1, 1);
    finish_hit();
    chk("spur_index", idx_cap, 3'd3);
    chk("spur_word0", line_cap[31:0], 32'h01020304);
    chk("spur_addr", addr_cap, 32'h12345660);

    // Reset after four beats, with beats still arriving.
    pcOut = 32'h00B000A0; req_valid = 1; hit = 0;
    tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid = 1; mem_rdata = 32'hC0DE0000 + b;
      tick();
    end
    reset = 0; req_valid = 0;
    #2;
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    chk("midrst_mem_req", mem_req, 1'b0);
    tick();
    reset = 1;
    tick();
    mem_rvalid = 0;
    refill(32'h00C00040, 0, -1, 0, 32'h01010101, 0, 0);
    finish_hit();
    chk("restart_fill_cycle", fill_cyc - t0, 10);
    chk("restart_word0", line_cap[31:0], 32'h01010101);
    chk("restart_word7", line_cap[255:224], 32'h08080808);
    chk("restart_index", idx_cap, 3'd2);

    // Back-to-back misses: the second starts in the cycle after FILL.
    refill(32'h00D00020, 0, -1, 0, 32'h10000001, 0, 0);
    a_fill = fill_cyc;
    refill(32'h00E000E4, 1, -1, 0, 32'h20000002, 0, 0);
    finish_hit();
    chk("b2b_start", t0, a_fill + 1);
    chk("b2b_addr", addr_cap, 32'h00E000E0);
    chk("b2b_fill_cycle", fill_cyc - t0, 11);
    chk("b2b_index", idx_cap, 3'd7);
    chk("b2b_word7", line_cap[255:224], 32'h00000010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill controller sitting directly upstream of the 2-way instruction/data cache. It watches the cache's `hit` for the current `pcOut` and freezes the pipeline via `stall` on a miss. It fetches the missing 32-byte line from memory as eight 32-bit beats, assembles the 256-bit line, and presents it to the cache with a one-cycle `fill_en` strobe. The cache's FIFO replacement selects the victim way; this block only supplies the line and its timing.

## Interface
- `BEATS`, 8: memory beats per line.
- `BEAT_W`, 32: bits per beat.
- `LINE_W`, 256: line width; must equal `BEATS*BEAT_W`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Despite the name, 0 = reset asserted.
- `req_valid`  in  1  the pipeline is presenting a real access on `pcOut` this cycle.
- `hit`  in  1  cache hit for the current `pcOut`.
- `pcOut`  in  32  access address; `[31:5]` is the line address.
- `mem_req`  out  1  line read request to memory.
- `mem_addr`  out  32  line-aligned address, `{line_addr, 5'b0}`.
- `mem_gnt`  in  1  memory accepted the request.
- `mem_rvalid`  in  1  a read beat is valid.
- `mem_rdata`  in  32  beat data, lowest word first.
- `stall`  out  1  freeze the pipeline.
- `fill_en`  out  1  write `fill_line` into the cache at the latched index.
- `fill_line`  out  256  assembled line.
- `fill_index`  out  3  latched `pcOut[7:5]` of the missing line.

## Operation
- State machine with states IDLE, REQ, BEAT, FILL. Reset value is IDLE.
- **IDLE**
  - A miss is `req_valid & ~hit`.
  - On a miss, latch `pcOut[31:5]` into `line_addr`, clear `beat_cnt`, and go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `mem_req`=1 and `mem_addr` is held stable until `mem_gnt`=1.
  - On `mem_gnt`, go to BEAT.
  - `mem_rvalid` is ignored in REQ.
- **BEAT**
  - Each `mem_rvalid` writes `mem_rdata` into `line_buf[32*beat_cnt +: 32]`, then increments `beat_cnt`.
  - `beat_cnt` is 3 bits and wraps 7→0.
  - On the beat that fills slot 7, go to FILL.
  - Gaps between beats (`mem_rvalid`=0) are allowed and hold state.
- **FILL**
  - `fill_en`=1 for exactly one cycle.
  - `fill_line` = `line_buf`; `fill_index` = `line_addr[2:0]`.
  - Next state is IDLE unconditionally.
- **stall** = `(state != IDLE) | (state == IDLE & req_valid & ~hit)`.
  - Combinational, so the pipeline freezes in the same cycle the miss is seen.
- New misses, `pcOut` changes and `hit` changes while not in IDLE are ignored; the latched `line_addr` governs the refill.
- `mem_gnt` outside REQ and `mem_rvalid` outside BEAT are ignored.
- **Reset mid-refill:** state returns to IDLE and all outputs go to 0 immediately (asynchronous). `line_buf` is cleared to 0. Beats still in flight from memory are dropped, because `mem_rvalid` is ignored in IDLE.
- **Reset values:** `mem_req`=0, `mem_addr`=0, `stall`=0, `fill_en`=0, `fill_line`=0, `fill_index`=0.

## Timing
- Miss seen in cycle 0 → REQ from cycle 1.
- With `mem_gnt` in cycle 1 and back-to-back beats in cycles 2–9 → FILL in cycle 10 → IDLE in cycle 11.
- The cache updates on the edge that ends FILL, so `hit`=1 for the same `pcOut` in cycle 11 and `stall` drops.
- Minimum miss penalty is 11 stalled cycles (0–10). Each extra cycle of grant delay or beat gap adds one cycle.
- A hit in IDLE costs zero cycles; `stall` stays 0.
- `mem_req` rises one cycle after the miss and falls in the cycle after `mem_gnt`.
- `mem_addr` holds `{line_addr, 5'b0}` from REQ through FILL.

## Structure
- Shared cache package holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, BEAT=2'd2, FILL=2'd3;
  - `LINE_W`, `BEAT_W`, `BEATS`, and the offset width (5).
- One natural sub-module, `line_assembler`: holds `line_buf`, the beat counter and the slot-write decode, and outputs `last_beat`.
- The FSM, stall logic and memory handshake live in `cache_refill_ctrl`.

## Test plan
- **Reset:** `reset`=0 with random inputs → all outputs 0 and state IDLE. Deassert; `req_valid`=1, `hit`=1 → `stall` stays 0 and `mem_req` stays 0.
- **Basic miss:** `pcOut`=32'h00A00062, `hit`=0; `mem_gnt` next cycle; beats 32'h11111111…32'h88888888 back-to-back.
  - `mem_addr`=32'h00A00060.
  - `fill_en` pulses once in cycle 10 with `fill_line[31:0]`=32'h11111111, `fill_line[255:224]`=32'h88888888, `fill_index`=3.
  - `stall` high in cycles 0–10.
- **Delayed grant and gapped beats:** `mem_gnt` 4 cycles late, 2 idle cycles between beats 3 and 4 → `fill_en` 6 cycles later than the basic case; `mem_addr` stable throughout REQ.
- **Change and spurious inputs during refill:** change `pcOut` to 32'hABCDABC0 mid-BEAT; pulse `mem_rvalid` during REQ.
  - `fill_index` stays 3.
  - The spurious beat is not captured; `line_buf[31:0]` equals the first beat received in BEAT.
- **Reset mid-BEAT:** assert `reset` after 4 beats → state IDLE and `stall`=0 immediately. After release, a new miss restarts with `beat_cnt`=0 and the previous beats are not reused.
- **Back-to-back misses:** a miss in the cycle right after FILL with `hit`=0 at a new line → REQ entered again with the new `mem_addr` and no lost cycle.
